// File: rtl/alu_seq.sv
// alu_seq: sequential WIDTH-bit ALU with valid/ready handshakes on both sides.
//   Single-cycle ops (AND/OR/XOR/ADD/SUB/SLT/NOR) finish on the accept edge.
//   Shifts (SLL/SRL/SRA) move one bit per EXEC cycle.
//   MUL is shift-add over WIDTH EXEC cycles.
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   in_valid / in_ready        operation handshake (in_ready only in IDLE)
//   a, b, opcode               operands and 4-bit opcode, captured on accept
//   out_valid / out_ready      result handshake (out_valid only in DONE)
//   result                     registered result
//   zero, carry, overflow,
//   illegal                    registered flags
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             illegal
);
   localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_XOR = 4'b0010,
                          OP_ADD = 4'b0011, OP_SUB = 4'b0111, OP_SLT = 4'b0110,
                          OP_NOR = 4'b1100, OP_SLL = 4'b1000, OP_SRL = 4'b1001,
                          OP_SRA = 4'b1010, OP_MUL = 4'b1011;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d, res_q, res_d;
   logic [SHW:0]     cnt_q, cnt_d;
   logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, ill_q, ill_d;

   logic [SHW-1:0]   k;
   logic             is_sub, ovf, sc_c, sc_v, sc_ill, multi, fin;
   logic [WIDTH-1:0] bb, sc_res, x_sh, acc_n, ex_res;
   logic [WIDTH:0]   sum;

   assign k      = b[SHW-1:0];
   assign is_sub = opcode == OP_SUB || opcode == OP_SLT;
   assign bb     = is_sub ? ~b : b;
   assign sum    = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, is_sub};
   // carry into the MSB is recovered from the MSB sum bit and its two inputs
   assign ovf    = (a[WIDTH-1] ^ bb[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
   // a zero-distance shift completes like a single-cycle op
   assign multi  = opcode[3:2] == 2'b10 && (opcode == OP_MUL || k != '0);

   always_comb begin
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      sc_ill = 1'b0;
      case (opcode)
         OP_AND:                 sc_res = a & b;
         OP_OR:                  sc_res = a | b;
         OP_XOR:                 sc_res = a ^ b;
         OP_ADD, OP_SUB: begin
            sc_res = sum[WIDTH-1:0];
            sc_c   = sum[WIDTH];
            sc_v   = ovf;
         end
         OP_SLT:                 sc_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
         OP_NOR:                 sc_res = ~a & ~b;
         OP_SLL, OP_SRL, OP_SRA: sc_res = a;
         OP_MUL:                 sc_res = '0;
         default:                sc_ill = 1'b1;
      endcase
   end

   // x_q is the shifting operand for shifts and the multiplicand for MUL
   assign x_sh   = op_q == OP_SRL ? x_q >> 1 :
                   op_q == OP_SRA ? {x_q[WIDTH-1], x_q[WIDTH-1:1]} : x_q << 1;
   assign acc_n  = acc_q + (y_q[0] ? x_q : '0);
   assign ex_res = op_q == OP_MUL ? acc_n : x_sh;
   assign fin    = cnt_q == (SHW+1)'(1);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      x_d     = x_q;
      y_d     = y_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      ill_d   = ill_q;
      case (state_q)
         IDLE: if (in_valid) begin
            op_d  = opcode;
            x_d   = a;
            y_d   = b;
            acc_d = '0;
            cnt_d = opcode == OP_MUL ? (SHW+1)'(WIDTH) : {1'b0, k};
            if (multi) begin
               state_d = EXEC;
            end else begin
               state_d = DONE;
               res_d   = sc_res;
               zero_d  = sc_res == '0;
               carry_d = sc_c;
               ovf_d   = sc_v;
               ill_d   = sc_ill;
            end
         end
         EXEC: begin
            x_d   = x_sh;
            y_d   = y_q >> 1;
            acc_d = acc_n;
            cnt_d = cnt_q - (SHW+1)'(1);
            if (fin) begin
               state_d = DONE;
               res_d   = ex_res;
               zero_d  = ex_res == '0;
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               ill_d   = 1'b0;
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         x_q     <= x_d;
         y_q     <= y_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         ill_q   <= ill_d;
      end
   end

   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign result    = res_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;
   assign illegal   = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
   logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic [3:0]  opcode = '0;
   logic        in_ready, out_valid, zero, carry, overflow, illegal;
   logic [31:0] result;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .carry(carry), .overflow(overflow), .illegal(illegal)
   );

   // returns {illegal, overflow, carry, zero, result}
   function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [32:0] s;
      logic [31:0] r;
      logic        c, v, il;
      int          sh;
      r = '0; c = 1'b0; v = 1'b0; il = 1'b0; sh = int'(y[4:0]);
      case (op)
         4'h0: r = x & y;
         4'h1: r = x | y;
         4'h2: r = x ^ y;
         4'h3: begin
            s = {1'b0, x} + {1'b0, y};
            r = s[31:0];
            c = s[32];
            v = (x[31] == y[31]) && (r[31] != x[31]);
         end
         4'h7: begin
            r = x - y;
            c = x >= y;
            v = (x[31] != y[31]) && (r[31] != x[31]);
         end
         4'h6: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'hC: r = ~(x | y);
         4'h8: r = x << sh;
         4'h9: r = x >> sh;
         4'hA: r = $unsigned($signed(x) >>> sh);
         4'hB: r = x * y;
         default: il = 1'b1;
      endcase
      return {il, v, c, r == 32'd0, r};
   endfunction

   // clock edges after the accept edge until out_valid rises
   function automatic int lat_of(input logic [3:0] op, input logic [31:0] y);
      if (op == 4'hB) return 32;
      if (op == 4'h8 || op == 4'h9 || op == 4'hA) return int'(y[4:0]);
      return 0;
   endfunction

   logic [3:0]  d_op [10] = '{4'h3, 4'h7, 4'h6, 4'h6, 4'hB, 4'hB, 4'hA, 4'h9, 4'h8, 4'h8};
   logic [31:0] d_a  [10] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd1, 32'h00010003,
                              32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h12345678, 32'd1};
   logic [31:0] d_b  [10] = '{32'd1, 32'd5, 32'd1, 32'hFFFFFFFF, 32'd5,
                              32'hFFFFFFFF, 32'd4, 32'd4, 32'hFFFFFFE0, 32'd31};
   logic [31:0] d_r  [10] = '{32'h80000000, 32'd0, 32'd1, 32'd0, 32'h0005000F,
                              32'd1, 32'hF8000000, 32'h08000000, 32'h12345678, 32'h80000000};

   // drives one op, scrambles the inputs after accept, waits for out_valid (bounded)
   task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        output int n, output bit ready_seen);
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      in_valid = 1'b1; a = x; b = y; opcode = op;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; a = $urandom; b = $urandom; opcode = 4'($urandom);
      n = 0; ready_seen = 1'b0;
      while (!out_valid && n < 100) begin
         if (in_ready) ready_seen = 1'b1;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_handshake: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
      total++;
      if (result !== 32'd0) begin
         bad++;
         $display("FAIL reset_result: got %h want 0", result);
      end
      total++;
      if ({zero, carry, overflow, illegal} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_flags: got %b want 0000", {zero, carry, overflow, illegal});
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_directed();
      int n;
      bit rs;
      logic [35:0] exp;
      for (int i = 0; i < 10; i++) begin
         exp = model(d_op[i], d_a[i], d_b[i]);
         issue(d_op[i], d_a[i], d_b[i], n, rs);
         total++;
         if (result !== d_r[i]) begin
            bad++;
            $display("FAIL dir%0d_result op=%h: got %h want %h", i, d_op[i], result, d_r[i]);
         end
         total++;
         if ({illegal, overflow, carry, zero} !== exp[35:32]) begin
            bad++;
            $display("FAIL dir%0d_flags op=%h: got %b want %b", i, d_op[i], {illegal, overflow, carry, zero}, exp[35:32]);
         end
         total++;
         if (n !== lat_of(d_op[i], d_b[i]) || rs) begin
            bad++;
            $display("FAIL dir%0d_latency op=%h: got %0d ready_seen=%b want %0d", i, d_op[i], n, rs, lat_of(d_op[i], d_b[i]));
         end
         pop();
      end
   endtask

   task automatic test_random();
      int n;
      bit rs;
      logic [3:0]  op;
      logic [31:0] x, y;
      logic [35:0] exp;
      for (int i = 0; i < 80; i++) begin
         op = 4'($urandom_range(0, 15));
         x = $urandom;
         y = (i % 4 == 0) ? x : $urandom;
         exp = model(op, x, y);
         issue(op, x, y, n, rs);
         total++;
         if ({illegal, overflow, carry, zero, result} !== exp) begin
            bad++;
            $display("FAIL rnd%0d op=%h a=%h b=%h: got %b/%h want %b/%h", i, op, x, y,
                     {illegal, overflow, carry, zero}, result, exp[35:32], exp[31:0]);
         end
         total++;
         if (n !== lat_of(op, y) || rs) begin
            bad++;
            $display("FAIL rnd%0d_latency op=%h: got %0d ready_seen=%b want %0d", i, op, n, rs, lat_of(op, y));
         end
         pop();
      end
   endtask

   task automatic test_backpressure();
      int n;
      bit rs;
      logic [35:0] exp, exp2;
      exp  = model(4'h3, 32'h7FFFFFFF, 32'd1);
      exp2 = model(4'h2, 32'hA5A5F00F, 32'h0FF0FFFF);
      issue(4'h3, 32'h7FFFFFFF, 32'd1, n, rs);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if ({illegal, overflow, carry, zero, result} !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold%0d: got %b/%h v=%b r=%b want %b/%h v=1 r=0", i,
                     {illegal, overflow, carry, zero}, result, out_valid, in_ready, exp[35:32], exp[31:0]);
         end
      end
      in_valid = 1'b1; a = 32'hA5A5F00F; b = 32'h0FF0FFFF; opcode = 4'h2; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== exp[31:0]) begin
         bad++;
         $display("FAIL bp_pop: v=%b r=%b result=%h want v=0 r=1 result=%h", out_valid, in_ready, result, exp[31:0]);
      end
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || {illegal, overflow, carry, zero, result} !== exp2) begin
         bad++;
         $display("FAIL bp_queued: v=%b got %b/%h want v=1 %b/%h", out_valid,
                  {illegal, overflow, carry, zero}, result, exp2[35:32], exp2[31:0]);
      end
      pop();
   endtask

   task automatic test_reset_abort();
      int n;
      bit rs, seen;
      issue(4'h3, 32'h80000000, 32'h80000001, n, rs);
      total++;
      if ({illegal, overflow, carry, zero, result} !== {4'b0110, 32'd1}) begin
         bad++;
         $display("FAIL abort_setup: got %b/%h want 0110/00000001", {illegal, overflow, carry, zero}, result);
      end
      pop();
      in_valid = 1'b1; a = 32'h00010003; b = 32'd5; opcode = 4'hB;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 ||
          {zero, carry, overflow, illegal} !== 4'b0000) begin
         bad++;
         $display("FAIL abort_reset: r=%b v=%b result=%h flags=%b want 1 0 0 0000", in_ready, out_valid,
                  result, {zero, carry, overflow, illegal});
      end
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL abort_no_output: out_valid got 1 want 0");
      end
      issue(4'b0100, $urandom, $urandom, n, rs);
      total++;
      if ({illegal, overflow, carry, zero, result} !== {4'b1001, 32'd0} || n !== 0) begin
         bad++;
         $display("FAIL illegal_op: got %b/%h lat=%0d want 1001/00000000 lat=0", {illegal, overflow, carry, zero}, result, n);
      end
      pop();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_random();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
